// File: rtl/mem_io_bridge_pkg.sv
// mem_io_bridge shared definitions: FSM states, access sizes, IO slots,
// and the byte-lane helpers used for stores and load extension.
package mem_io_bridge_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM_WAIT,
        S_RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // IO map: N_OUT output slots, then switch slot, then status slot
    localparam int unsigned IO_STRIDE  = 4;
    localparam int unsigned IO_SW_SLOT = 0;
    localparam int unsigned IO_ST_SLOT = 1;

    function automatic logic [3:0] lane_be(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [3:0] be;
        unique case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] load_ext(
        input logic [31:0] word,
        input logic [2:0]  f3,
        input logic [1:0]  off
    );
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {off, 3'b000};
        unique case (f3[1:0])
            SZ_BYTE: r = f3[2] ? {24'b0, sh[7:0]}
                               : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: r = f3[2] ? {16'b0, sh[15:0]}
                               : {{16{sh[15]}}, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_io_bridge_io_sync.sv
// io_sync: STAGES-deep flop chain bringing asynchronous inputs into clk_i.
// Ports: clk_i, rst_n_i (async low), d_i (async in), q_o (synced out).
module io_sync
    import mem_io_bridge_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] chain_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < STAGES; i++) chain_q[i] <= '0;
        end else begin
            chain_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: datapath load/store port split into a memory bus and a
// small IO window (output regs, synced switches, optional IRQ status).
// Ports: clk_i/rst_n_i; req_i/we_i/funct3_i/addr_i/wdata_i from datapath;
// rdata_o/done_o/err_o/stall_o back; mem_* bus; sw_i in; out_o, irq_o out.
// Build option: define IO_IRQ_EN for the switch-rise interrupt status reg.
module mem_io_bridge
    import mem_io_bridge_pkg::*;
#(
    parameter logic [31:0] IO_BASE     = 32'h100,
    parameter int          N_OUT       = 2,
    parameter int          OUT_W       = 4,
    parameter int          IN_W        = 4,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [2:0]             funct3_i,
    input  logic [31:0]            addr_i,
    input  logic [31:0]            wdata_i,
    output logic [31:0]            rdata_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic                   stall_o,
    output logic                   mem_req_o,
    output logic [3:0]             mem_be_o,
    output logic [31:0]            mem_addr_o,
    output logic [31:0]            mem_wdata_o,
    input  logic [31:0]            mem_rdata_i,
    input  logic                   mem_ack_i,
    input  logic [IN_W-1:0]        sw_i,
    output logic [N_OUT*OUT_W-1:0] out_o,
    output logic                   irq_o
);

    localparam logic [31:0] SW_ADDR =
        IO_BASE + 32'(IO_STRIDE * (N_OUT + IO_SW_SLOT));
    localparam logic [31:0] ST_ADDR =
        IO_BASE + 32'(IO_STRIDE * (N_OUT + IO_ST_SLOT));

    state_t           state_q, state_d;
    logic [IN_W-1:0]  sw_sync;
    logic [IN_W-1:0]  irq_stat;
    logic [OUT_W-1:0] out_q [N_OUT];
    logic [31:0]      waddr, lane_wd, io_rword;
    logic [29:0]      woff;
    logic [31:0]      rdata_q, mem_addr_q, mem_wdata_q;
    logic [3:0]       be_q;
    logic             err_q, we_q;
    logic [2:0]       f3_q;
    logic [1:0]       boff_q;
    logic             accept, bad;
    logic             is_out, is_sw, is_st, is_io;

    io_sync #(
        .WIDTH (IN_W),
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .d_i    (sw_i),
        .q_o    (sw_sync)
    );

    assign waddr   = {addr_i[31:2], 2'b00};
    assign woff    = addr_i[31:2] - IO_BASE[31:2];
    assign lane_wd = wdata_i << {addr_i[1:0], 3'b000};
    assign accept  = (state_q == S_IDLE) && req_i;

    assign bad = (funct3_i[1:0] == SZ_ILL)
               | ((funct3_i[1:0] == SZ_HALF) & addr_i[0])
               | ((funct3_i[1:0] == SZ_WORD) & (|addr_i[1:0]));

    assign is_out = (addr_i[31:2] >= IO_BASE[31:2])
                  && (woff < 30'(N_OUT));
    assign is_sw  = (waddr == SW_ADDR);
`ifdef IO_IRQ_EN
    assign is_st  = (waddr == ST_ADDR);
`else
    assign is_st  = 1'b0;
`endif
    assign is_io  = is_out | is_sw | is_st;

    always_comb begin
        io_rword = '0;
        if (is_sw) io_rword = 32'(sw_sync);
        if (is_st) io_rword = 32'(irq_stat);
        for (int k = 0; k < N_OUT; k++) begin
            if (is_out && woff == 30'(k)) io_rword = 32'(out_q[k]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    state_d = (bad || is_io) ? S_RESP : S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: if (mem_ack_i) state_d = S_RESP;
            S_RESP:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Request is latched on IDLE exit; IO reads sample on that same edge
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            we_q        <= 1'b0;
            f3_q        <= '0;
            boff_q      <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            be_q        <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if (accept) begin
                we_q   <= we_i;
                f3_q   <= funct3_i;
                boff_q <= addr_i[1:0];
                err_q  <= bad;
                if (bad) begin
                    rdata_q <= '0;
                end else if (is_io) begin
                    rdata_q <= we_i ? '0
                             : load_ext(io_rword, funct3_i, addr_i[1:0]);
                end else begin
                    mem_addr_q  <= waddr;
                    mem_wdata_q <= lane_wd;
                    be_q        <= we_i ? lane_be(funct3_i[1:0], addr_i[1:0])
                                        : 4'b0000;
                end
            end
            if (state_q == S_MEM_WAIT && mem_ack_i) begin
                rdata_q <= we_q ? '0 : load_ext(mem_rdata_i, f3_q, boff_q);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
        end else if (accept && !bad && we_i && is_out) begin
            for (int k = 0; k < N_OUT; k++) begin
                if (woff == 30'(k)) out_q[k] <= lane_wd[OUT_W-1:0];
            end
        end
    end

`ifdef IO_IRQ_EN
    logic [IN_W-1:0] sw_prev, st_clr;

    assign st_clr = (accept && !bad && we_i && is_st)
                  ? lane_wd[IN_W-1:0] : '0;

    // A rise in the same cycle as a clear keeps the bit set
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sw_prev  <= '0;
            irq_stat <= '0;
        end else begin
            sw_prev  <= sw_sync;
            irq_stat <= (irq_stat & ~st_clr) | (sw_sync & ~sw_prev);
        end
    end

    assign irq_o = |irq_stat;
`else
    assign irq_stat = '0;
    assign irq_o    = 1'b0;
`endif

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        assign out_o[k*OUT_W +: OUT_W] = out_q[k];
    end

    assign done_o      = (state_q == S_RESP);
    assign err_o       = done_o & err_q;
    assign rdata_o     = rdata_q;
    assign stall_o     = req_i & ~done_o;
    assign mem_req_o   = (state_q == S_MEM_WAIT);
    assign mem_be_o    = mem_req_o ? be_q : 4'b0000;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Testbench for mem_io_bridge: directed vector table, hand sequences for
// sync/IRQ and reset-in-flight, then random accesses against a ref model.
module tb_mem_io_bridge;

    localparam logic [31:0] IO_BASE = 32'h100;
    localparam int N_OUT = 2;
    localparam int OUT_W = 4;
    localparam int IN_W  = 4;
    localparam int SYNC  = 2;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        done_o, err_o, stall_o;
    logic        mem_req_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;
    logic [3:0]  sw_i = '0;
    logic [7:0]  out_o;
    logic        irq_o;

    int nchk = 0;
    int nerr = 0;

    mem_io_bridge #(
        .IO_BASE    (IO_BASE),
        .N_OUT      (N_OUT),
        .OUT_W      (OUT_W),
        .IN_W       (IN_W),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .req_i      (req_i),
        .we_i       (we_i),
        .funct3_i   (funct3_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .stall_o    (stall_o),
        .mem_req_o  (mem_req_o),
        .mem_be_o   (mem_be_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_ack_i  (mem_ack_i),
        .sw_i       (sw_i),
        .out_o      (out_o),
        .irq_o      (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference model state
    logic [3:0]  ref_out [N_OUT];
    logic [3:0]  ref_irq = '0;
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] wa);
        if (ref_mem.exists(wa)) return ref_mem[wa];
        return wa ^ 32'hC3A5_5A3C;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w,
                                             input logic [2:0] f3,
                                             input int off);
        logic [31:0] v;
        int n;
        v = w >> (8 * off);
        n = (f3[1:0] == 2'd0) ? 8 : (f3[1:0] == 2'd1) ? 16 : 32;
        if (n < 32) begin
            v = v & ((32'd1 << n) - 32'd1);
            if (!f3[2] && v[n-1]) v = v - (32'd1 << n);
        end
        return v;
    endfunction

    // One full datapath access; waitc = mem_req cycles before the ack
    task automatic access(
        input  logic        we, input logic [2:0] f3,
        input  logic [31:0] a, input logic [31:0] wd,
        input  logic [31:0] mr, input int waitc,
        output logic        saw_mem, output logic [3:0] be,
        output logic [31:0] ma, output logic [31:0] mwd,
        output logic        err, output logic [31:0] rd,
        output int          cyc
    );
        int  ack_cnt;
        logic stable_bad, stall_bad, done_seen;
        saw_mem = 0; be = '0; ma = '0; mwd = '0; err = 0; rd = '0;
        cyc = 0; ack_cnt = 0;
        stable_bad = 0; stall_bad = 0; done_seen = 0;
        req_i = 1; we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd;
        while (!done_seen && cyc < 30) begin
            @(negedge clk_i);
            cyc++;
            mem_ack_i = 0;
            if (done_o) begin
                done_seen = 1;
                err = err_o;
                rd = rdata_o;
                if (stall_o) stall_bad = 1;
            end else begin
                if (!stall_o) stall_bad = 1;
                if (mem_req_o) begin
                    if (!saw_mem) begin
                        saw_mem = 1;
                        be = mem_be_o; ma = mem_addr_o; mwd = mem_wdata_o;
                    end else if (be !== mem_be_o || ma !== mem_addr_o
                                 || mwd !== mem_wdata_o) begin
                        stable_bad = 1;
                    end
                    if (ack_cnt == waitc) begin
                        mem_ack_i = 1;
                        mem_rdata_i = mr;
                    end
                    ack_cnt++;
                end
            end
        end
        req_i = 0;
        chk("done_seen", 32'(done_seen), 32'd1);
        chk("mem_stable", 32'(stable_bad), 32'd0);
        chk("stall", 32'(stall_bad), 32'd0);
        @(negedge clk_i);
        mem_ack_i = 0;
        chk("done_pulse", 32'(done_o), 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a, wd, mr;
        int          waitc;
        logic        exp_mem;
        logic [3:0]  exp_be;
        logic [31:0] exp_ma, exp_mwd;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
        int          exp_cyc;
        logic [7:0]  exp_out;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic        sm, e;
        logic [3:0]  be;
        logic [31:0] ma, mwd, rd;
        int          cyc;

        tbl[0]  = '{1, 3'b000, 32'h2003, 32'hA5, 0, 3, 1, 4'b1000,
                    32'h2000, 32'hA500_0000, 0, 0, 0, 5, 8'h00};
        tbl[1]  = '{0, 3'b001, 32'h2002, 0, 32'h8001_1234, 0, 1, 4'b0000,
                    32'h2000, 0, 0, 1, 32'hFFFF_8001, 2, 8'h00};
        tbl[2]  = '{0, 3'b101, 32'h2002, 0, 32'h8001_1234, 0, 1, 4'b0000,
                    32'h2000, 0, 0, 1, 32'h0000_8001, 2, 8'h00};
        tbl[3]  = '{1, 3'b010, 32'h104, 32'hF, 0, 0, 0, 4'b0000,
                    0, 0, 0, 0, 0, 1, 8'hF0};
        tbl[4]  = '{0, 3'b010, 32'h2002, 0, 0, 0, 0, 4'b0000,
                    0, 0, 1, 1, 0, 1, 8'hF0};
        tbl[5]  = '{0, 3'b000, 32'h2001, 0, 32'h0000_8000, 1, 1, 4'b0000,
                    32'h2000, 0, 0, 1, 32'hFFFF_FF80, 3, 8'hF0};
        tbl[6]  = '{1, 3'b001, 32'h2002, 32'h1234_BEEF, 0, 0, 1, 4'b1100,
                    32'h2000, 32'hBEEF_0000, 0, 0, 0, 2, 8'hF0};
        tbl[7]  = '{1, 3'b011, 32'h2000, 32'h55, 0, 0, 0, 4'b0000,
                    0, 0, 1, 1, 0, 1, 8'hF0};
        tbl[8]  = '{1, 3'b000, 32'h100, 32'h37, 0, 0, 0, 4'b0000,
                    0, 0, 0, 0, 0, 1, 8'hF7};
        tbl[9]  = '{0, 3'b010, 32'h104, 0, 0, 0, 0, 4'b0000,
                    0, 0, 0, 1, 32'hF, 1, 8'hF7};
        tbl[10] = '{1, 3'b001, 32'h106, 32'h5, 0, 0, 0, 4'b0000,
                    0, 0, 0, 0, 0, 1, 8'h07};
        tbl[11] = '{0, 3'b100, 32'h100, 0, 0, 0, 0, 4'b0000,
                    0, 0, 0, 1, 32'h7, 1, 8'h07};
        tbl[12] = '{1, 3'b001, 32'h2001, 32'h1, 0, 0, 0, 4'b0000,
                    0, 0, 1, 1, 0, 1, 8'h07};

        // Reset state
        #2;
        chk("rst_out", 32'(out_o), 0);
        chk("rst_mem_req", 32'(mem_req_o), 0);
        chk("rst_be", 32'(mem_be_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_irq", 32'(irq_o), 0);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1;
        @(negedge clk_i);

        foreach (tbl[i]) begin
            access(tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].mr,
                   tbl[i].waitc, sm, be, ma, mwd, e, rd, cyc);
            chk($sformatf("v%0d_mem", i), 32'(sm), 32'(tbl[i].exp_mem));
            chk($sformatf("v%0d_cyc", i), cyc, tbl[i].exp_cyc);
            chk($sformatf("v%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
            if (tbl[i].exp_mem) begin
                chk($sformatf("v%0d_be", i), 32'(be), 32'(tbl[i].exp_be));
                chk($sformatf("v%0d_ma", i), ma, tbl[i].exp_ma);
                if (tbl[i].we)
                    chk($sformatf("v%0d_mwd", i), mwd, tbl[i].exp_mwd);
            end
            if (tbl[i].chk_rd)
                chk($sformatf("v%0d_rd", i), rd, tbl[i].exp_rd);
            chk($sformatf("v%0d_out", i), 32'(out_o), 32'(tbl[i].exp_out));
        end
        ref_out[0] = 4'h7;
        ref_out[1] = 4'h0;

        // Switch sync, then read the switch slot
        sw_i = 4'b0100;
        repeat (SYNC + 1) @(negedge clk_i);
        access(0, 3'b010, 32'h108, 0, 0, 0, sm, be, ma, mwd, e, rd, cyc);
        chk("sw_read", rd, 32'h4);
        chk("sw_nomem", 32'(sm), 0);
`ifdef IO_IRQ_EN
        chk("irq_set", 32'(irq_o), 1);
        access(1, 3'b010, 32'h10C, 32'h4, 0, 0, sm, be, ma, mwd, e, rd, cyc);
        chk("irq_clr", 32'(irq_o), 0);
`else
        chk("irq_off", 32'(irq_o), 0);
`endif

        // Random accesses against the reference model
        for (int n = 0; n < 80; n++) begin
            logic        we, err_e;
            logic [2:0]  f3;
            logic [31:0] a, wd, wa, mr, word, lane;
            logic [3:0]  exp_be;
            int          off, kind, k, waitc, nb;
            we = 1'($urandom);
            f3 = 3'($urandom);
            a = ($urandom % 2) ? (32'h100 + ($urandom % 16))
                               : (32'h2000 + ($urandom % 64));
            wd = $urandom;
            waitc = $urandom % 4;
            off = a % 4;
            wa = a - off;
            err_e = (f3[1:0] == 3) || (f3[1:0] == 1 && off % 2 != 0)
                 || (f3[1:0] == 2 && off != 0);
            kind = 0; k = 0;
            if (wa >= IO_BASE && wa < IO_BASE + 4 * N_OUT) begin
                kind = 1; k = (wa - IO_BASE) / 4;
            end else if (wa == IO_BASE + 4 * N_OUT) kind = 2;
`ifdef IO_IRQ_EN
            else if (wa == IO_BASE + 4 * N_OUT + 4) kind = 3;
`endif
            mr = mem_rd(wa);
            access(we, f3, a, wd, mr, waitc, sm, be, ma, mwd, e, rd, cyc);
            chk("r_err", 32'(e), 32'(err_e));
            chk("r_mem", 32'(sm), 32'(!err_e && kind == 0));
            chk("r_cyc", cyc, (err_e || kind != 0) ? 1 : waitc + 2);
            lane = wd << (8 * off);
            nb = 1 << f3[1:0];
            exp_be = '0;
            if (we) for (int j = 0; j < nb && j < 4; j++) exp_be[off+j] = 1;
            if (sm) begin
                chk("r_ma", ma, wa);
                chk("r_be", 32'(be), 32'(exp_be));
                if (we) chk("r_mwd", mwd, lane);
            end
            if (err_e) chk("r_rd_err", rd, 0);
            else if (!we) begin
                case (kind)
                    0: word = mr;
                    1: word = 32'(ref_out[k]);
                    2: word = 32'(sw_i);
                    default: word = 32'(ref_irq);
                endcase
                chk("r_rd", rd, ref_load(word, f3, off));
            end
            if (!err_e && we) begin
                if (kind == 1) ref_out[k] = lane[3:0];
                else if (kind == 3) ref_irq = ref_irq & ~lane[3:0];
                else if (kind == 0) begin
                    word = mem_rd(wa);
                    for (int j = 0; j < nb && j < 4; j++)
                        word[8*(off+j) +: 8] = wd[8*j +: 8];
                    ref_mem[wa] = word;
                end
            end
            chk("r_out", 32'(out_o), {24'b0, ref_out[1], ref_out[0]});
            chk("r_irq", 32'(irq_o), 32'(ref_irq != 0));
        end

        // Reset while waiting on memory; the late ack must be ignored
        sw_i = 4'b0000;
        req_i = 1; we_i = 0; funct3_i = 3'b010;
        addr_i = 32'h2010; wdata_i = 0;
        @(negedge clk_i);
        chk("mw_req", 32'(mem_req_o), 1);
        @(negedge clk_i);
        rst_n_i = 0;
        #1;
        chk("mw_rst_req", 32'(mem_req_o), 0);
        chk("mw_rst_be", 32'(mem_be_o), 0);
        chk("mw_rst_out", 32'(out_o), 0);
        req_i = 0;
        @(negedge clk_i);
        rst_n_i = 1;
        mem_ack_i = 1;
        mem_rdata_i = 32'hDEAD_BEEF;
        begin
            logic any_done, any_req;
            any_done = 0; any_req = 0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk_i);
                mem_ack_i = 0;
                any_done |= done_o;
                any_req |= mem_req_o;
            end
            chk("late_ack_done", 32'(any_done), 0);
            chk("late_ack_req", 32'(any_req), 0);
            chk("late_ack_rdata", rdata_o, 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mem_io_bridge.md
MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 SHALL have parameter IO_BASE, default 32'h100, base byte address of the IO window.
REQ-002 SHALL have parameter N_OUT, default 2, number of output registers (1..8).
REQ-003 SHALL have parameter OUT_W, default 4, width of each output register (1..32).
REQ-004 SHALL have parameter IN_W, default 4, width of the switch input (1..32).
REQ-005 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth for sw_i (>=2).
REQ-006 SHALL have ports, clock and reset first:
 clk_i  in  1  clock; all state on rising edge
 rst_n_i  in  1  reset, asynchronous, active-low
 req_i  in  1  access request from datapath, held until done_o
 we_i  in  1  1 = store, 0 = load
 funct3_i  in  3  [1:0] size 00 byte / 01 half / 10 word / 11 illegal; [2] 1 = zero-extend load
 addr_i  in  32  byte address
 wdata_i  in  32  store data, LSB-aligned
 rdata_o  out  32  extended load data, valid with done_o
 done_o  out  1  one-cycle access completion pulse
 err_o  out  1  with done_o: misaligned or illegal size
 stall_o  out  1  datapath hold
 mem_req_o  out  1  memory request, held until mem_ack_i
 mem_be_o  out  4  byte enables; all zero for loads
 mem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
 mem_wdata_o  out  32  lane-shifted store data
 mem_rdata_i  in  32  memory read word
 mem_ack_i  in  1  memory completion, any latency >= 1 cycle
 sw_i  in  IN_W  asynchronous switch inputs
 out_o  out  N_OUT*OUT_W  output registers concatenated, register k at [k*OUT_W +: OUT_W]
 irq_o  out  1  input-change interrupt (IO_IRQ_EN only; else tied 0)

Function
REQ-007 IO window SHALL be IO_BASE+4k: output reg k (k<N_OUT, R/W); IO_BASE+4*N_OUT: synced switch value (RO, zero-extended); IO_BASE+4*N_OUT+4: IRQ status (IO_IRQ_EN only); other addresses SHALL go to memory.
REQ-008 FSM states IDLE, MEM_WAIT, RESP; request fields SHALL be captured on IDLE exit.
REQ-009 IDLE + req_i: size 11 or misaligned (half addr[0]=1; word addr[1:0]!=0) -> RESP with err_o=1, no memory request, no register write.
REQ-010 IDLE + req_i + IO address -> RESP next cycle; IO writes commit on the IDLE-exit edge; IO reads sample on the same edge.
REQ-011 IDLE + req_i + memory address -> MEM_WAIT; mem_req_o=1 and mem_* stable throughout MEM_WAIT; mem_ack_i -> RESP, capture mem_rdata_i.
REQ-012 RESP SHALL assert done_o for exactly one cycle, then return to IDLE; a new req_i is accepted only in IDLE.
REQ-013 stall_o SHALL equal req_i & ~done_o.
REQ-014 Byte store: mem_be_o=4'b0001<<addr[1:0], data shifted 8*addr[1:0]; half: 4'b0011<<addr[1:0]; word: 4'b1111.
REQ-015 Loads SHALL right-shift by 8*addr[1:0], then sign- or zero-extend per funct3_i[2].
REQ-016 IO register writes SHALL use the lane-shifted data's low OUT_W bits of the addressed word; sub-word IO stores are permitted.
REQ-017 rdata_o SHALL be 0 when err_o=1, and hold its value outside done_o.

Reset
REQ-018 Reset SHALL force IDLE, mem_req_o=0, mem_be_o=0, done_o=0, err_o=0, rdata_o=0, out_o=0, sync chain=0, irq state=0, including mid-MEM_WAIT; a late mem_ack_i after reset SHALL be ignored.

Configuration
REQ-019 With IO_IRQ_EN defined: a 0->1 transition of any synced sw_i bit SHALL set the matching status bit; irq_o = |status; writing 1s to the status address SHALL clear those bits, with set winning over a same-cycle clear. Without it: no status register, that address maps to memory, irq_o=0.

Structure
REQ-020 Shared package SHALL hold the FSM state enum, size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and IO offset constants.
REQ-021 A sub-module io_sync (SYNC_STAGES-deep flop chain, parameter width) SHALL synchronise sw_i.

Verification
REQ-022 Store byte 0xA5 at 0x2003, mem_ack_i after 3 cycles -> mem_be_o=1000, mem_wdata_o=0xA5000000, done_o on cycle 5.
REQ-023 Load half, signed, 0x2002, mem_rdata_i=0x8001_1234 -> rdata_o=0xFFFF8001; unsigned -> 0x00008001.
REQ-024 Store word 0x0000000F to 0x104 -> out_o[7:4]=F after 1 cycle; no mem_req_o.
REQ-025 Load word at 0x2002 -> err_o=1, done_o=1, rdata_o=0, no mem_req_o.
REQ-026 sw_i 0000->0100; read 0x108 after SYNC_STAGES+1 cycles -> 0x4; with IO_IRQ_EN irq_o=1, write 0x4 to 0x10C -> irq_o=0.
REQ-027 rst_n_i low during MEM_WAIT, then ack -> mem_req_o=0 immediately, no done_o.
